// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divisor helpers.
// Reused by both the RX and TX sides of the UART.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_e;

  // Rounded clocks per 16x oversample tick.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + (baud * 8)) / (baud * 16);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversample tick generator: one-cycle pulse every DIV clocks.
// The clear input restarts the phase so the first tick lands DIV clocks later.
module uart_baud_gen #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_r;
  logic          tick_r;

  // Divider counter with registered tick pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= '0;
      tick_r    <= 1'b0;
    end else if (clear) begin
      div_cnt_r <= '0;
      tick_r    <= 1'b0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= '0;
      tick_r    <= 1'b1;
    end else begin
      div_cnt_r <= div_cnt_r + CW'(1);
      tick_r    <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver (8N1 by default) with 3-sample majority vote,
// glitch-rejecting start detection and break/stuck-low recovery.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [3:0] SMP_7  = 4'd7;
  localparam logic [3:0] SMP_8  = 4'd8;
  localparam logic [3:0] SMP_9  = 4'd9;
  localparam logic [3:0] SMP_15 = 4'd15;

  logic                  rx_meta_r, rx_sync_r, rx_prev_r;
  logic                  fall_s, tick_s, clear_s, vote_s;
  uart_state_e           state_r, state_nx_s;
  logic [3:0]            smp_cnt_r, smp_cnt_nx_s;
  logic [BIT_W-1:0]      bit_idx_r, bit_idx_nx_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_nx_s;
  logic [DATA_WIDTH-1:0] data_out_r, data_nx_s;
  logic                  smp7_r, smp8_r, bit_val_r;
  logic                  valid_r, valid_nx_s, frame_err_r, ferr_nx_s, busy_r;

  uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_s),
    .tick  (tick_s)
  );

  assign fall_s = rx_prev_r & ~rx_sync_r;
  assign vote_s = maj3(smp7_r, smp8_r, rx_sync_r);

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Hold samples 7 and 8; sample 9 resolves the bit by majority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp7_r    <= 1'b0;
      smp8_r    <= 1'b0;
      bit_val_r <= 1'b0;
    end else if (tick_s) begin
      if (smp_cnt_r == SMP_7) smp7_r <= rx_sync_r;
      if (smp_cnt_r == SMP_8) smp8_r <= rx_sync_r;
      if (smp_cnt_r == SMP_9) bit_val_r <= vote_s;
    end
  end

  // Next-state and datapath decode
  always_comb begin
    state_nx_s   = state_r;
    smp_cnt_nx_s = smp_cnt_r;
    bit_idx_nx_s = bit_idx_r;
    shift_nx_s   = shift_r;
    data_nx_s    = data_out_r;
    valid_nx_s   = 1'b0;
    ferr_nx_s    = 1'b0;
    clear_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        smp_cnt_nx_s = 4'd0;
        bit_idx_nx_s = '0;
        if (fall_s) begin
          state_nx_s = ST_START;
          clear_s    = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      // Glitch check at mid start bit; stay aligned to bit boundaries until sample 15
      ST_START: begin
        if (tick_s) begin
          smp_cnt_nx_s = smp_cnt_r + 4'd1;
          if ((smp_cnt_r == SMP_8) && rx_sync_r) begin
            state_nx_s = ST_IDLE;
          end else if (smp_cnt_r == SMP_15) begin
            state_nx_s   = ST_DATA;
            bit_idx_nx_s = '0;
          end else begin
            state_nx_s = ST_START;
          end
        end else begin
          state_nx_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s && (smp_cnt_r == SMP_15)) begin
          smp_cnt_nx_s = 4'd0;
          shift_nx_s   = {bit_val_r, shift_r[DATA_WIDTH-1:1]};
          if (bit_idx_r == BIT_LAST) begin
            state_nx_s = ST_STOP;
          end else begin
            bit_idx_nx_s = bit_idx_r + BIT_W'(1);
          end
        end else if (tick_s) begin
          smp_cnt_nx_s = smp_cnt_r + 4'd1;
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s && (smp_cnt_r == SMP_9)) begin
          if (vote_s) begin
            data_nx_s  = shift_r;
            valid_nx_s = 1'b1;
            state_nx_s = ST_IDLE;
          end else begin
            ferr_nx_s    = 1'b1;
            smp_cnt_nx_s = 4'd0;
            state_nx_s   = ST_WAIT_IDLE;
          end
        end else if (tick_s) begin
          smp_cnt_nx_s = smp_cnt_r + 4'd1;
        end else begin
          state_nx_s = ST_STOP;
        end
      end
      // Counts consecutive high ticks; any low tick restarts the count
      ST_WAIT_IDLE: begin
        if (tick_s && !rx_sync_r) begin
          smp_cnt_nx_s = 4'd0;
        end else if (tick_s && (smp_cnt_r == SMP_15)) begin
          smp_cnt_nx_s = 4'd0;
          state_nx_s   = ST_IDLE;
        end else if (tick_s) begin
          smp_cnt_nx_s = smp_cnt_r + 4'd1;
        end else begin
          state_nx_s = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_nx_s   = ST_IDLE;
        smp_cnt_nx_s = 4'd0;
        bit_idx_nx_s = '0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      smp_cnt_r   <= 4'd0;
      bit_idx_r   <= '0;
      shift_r     <= '0;
      data_out_r  <= '0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      smp_cnt_r   <= smp_cnt_nx_s;
      bit_idx_r   <= bit_idx_nx_s;
      shift_r     <= shift_nx_s;
      data_out_r  <= data_nx_s;
      valid_r     <= valid_nx_s;
      frame_err_r <= ferr_nx_s;
      busy_r      <= (state_nx_s != ST_IDLE);
    end
  end

  assign data_out  = data_out_r;
  assign valid     = valid_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench for uart_rx_os16 at default parameters (432 clocks per bit).
// Stimulus pushes expected events; a negedge monitor pops and compares on valid/frame_err.
module tb_uart_rx_os16;

  localparam int BIT_CLKS = 432;
  localparam int DIV      = 27;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       valid, frame_err, busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;
  int   n_ferr   = 0;
  logic valid_prev = 1'b0;
  exp_t exp_q[$];

  uart_rx_os16 dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every valid or frame_err pulse
  always @(negedge clk) begin
    if (!rst && (valid || frame_err)) begin
      check("valid_and_frame_err_exclusive", 32'(valid && frame_err), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_output_event", 32'(exp_q.size()), 32'd1);
      end else begin
        check("event_kind", 32'(frame_err), 32'(exp_q[0].is_err));
        check("data_out", 32'(data_out), 32'(exp_q[0].data));
        void'(exp_q.pop_front());
      end
    end
    if (!rst && valid) begin
      check("valid_one_cycle", 32'(valid_prev), 32'd0);
      n_valid <= n_valid + 1;
    end
    if (!rst && frame_err) n_ferr <= n_ferr + 1;
    valid_prev <= valid;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  // glitch_bit selects a data bit that gets a 3-clock low pulse around sample 8
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        rx = b[i];
        repeat (243) @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = b[i];
        repeat (BIT_CLKS - 246) @(posedge clk);
        #1;
      end else begin
        drive_bit(b[i]);
      end
    end
    drive_bit(stop_bit);
  endtask

  task automatic push(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int  cnt;
    logic [7:0] b3c;

    b3c = 8'h3C;
    repeat (5) @(posedge clk);
    #1;
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(50);

    // Plain frame
    push(1'b0, 8'h55);
    send_frame(8'h55, 1'b1, -1);
    idle(100);
    check("queue_drained_55", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames with no idle gap
    push(1'b0, 8'hA3);
    send_frame(8'hA3, 1'b1, -1);
    push(1'b0, 8'h0F);
    send_frame(8'h0F, 1'b1, -1);
    idle(100);
    check("queue_drained_b2b", 32'(exp_q.size()), 32'd0);

    // Short low pulse on an idle line must be rejected as a false start
    rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("busy_after_false_start", 32'(busy), 32'd1);
    repeat (50) @(posedge clk);
    #1 rx = 1'b1;
    cnt = 0;
    while (busy && cnt < 216 + DIV) begin
      @(posedge clk);
      #1 cnt++;
    end
    check("false_start_busy_drops", 32'(busy), 32'd0);
    idle(200);

    // Stop bit low followed by a long break: exactly one frame_err, data_out kept
    push(1'b1, 8'h0F);
    send_frame(8'hC8, 1'b0, -1);
    rx = 1'b0;
    repeat (5000) @(posedge clk);
    #1;
    check("busy_during_break", 32'(busy), 32'd1);
    rx  = 1'b1;
    cnt = 0;
    while (busy && cnt < 600) begin
      @(posedge clk);
      #1 cnt++;
    end
    check("break_recover_min", 32'(cnt >= 400), 32'd1);
    check("break_recover_max", 32'(cnt <= 445), 32'd1);
    check("queue_drained_break", 32'(exp_q.size()), 32'd0);
    idle(100);

    // Reset during bit 4 of 0x3C, then a clean 0x81
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b3c[i]);
    rx = b3c[4];
    repeat (200) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_data_out", 32'(data_out), 32'h0);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    idle(300);
    check("no_output_after_reset", 32'(data_out), 32'h0);
    push(1'b0, 8'h81);
    send_frame(8'h81, 1'b1, -1);
    idle(100);
    check("queue_drained_81", 32'(exp_q.size()), 32'd0);

    // Mid-bit glitch on 0xFF must be outvoted
    push(1'b0, 8'hFF);
    send_frame(8'hFF, 1'b1, 3);
    idle(100);
    check("queue_drained_ff", 32'(exp_q.size()), 32'd0);
    check("final_data_out", 32'(data_out), 32'hFF);

    idle(10);
    check("total_valid_pulses", 32'(n_valid), 32'd5);
    check("total_frame_err_pulses", 32'(n_ferr), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, data bits per frame.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port data_out  output  DATA_WIDTH  last received byte, LSB first on line.
REQ-008 SHALL have port valid  output  1  one-cycle pulse, data_out is new.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use; all "rx" below means the synchronized rx.
REQ-012 SHALL generate a 16x oversample tick every DIV = round(CLK_FREQ/(BAUD*16)) clocks (27 at defaults); tick is a one-cycle pulse.
REQ-013 SHALL clear the tick divisor and sample counter on the IDLE->START transition, so the first tick falls DIV clocks after the detected falling edge.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE: on synchronized rx 1->0 edge -> START; otherwise stay.
REQ-016 START: at sample 8 (mid start bit), rx high -> IDLE (glitch, no output); rx low -> DATA with sample count 0, bit index 0.
REQ-017 DATA: each bit value = majority of samples 7, 8, 9; on sample 15 shift into the shift register (LSB first); after bit DATA_WIDTH-1 -> STOP.
REQ-018 STOP: majority at samples 7-9; high -> load data_out, pulse valid next clock, -> IDLE; low -> pulse frame_err, keep data_out unchanged, -> WAIT_IDLE.
REQ-019 WAIT_IDLE: stay until rx high for 16 consecutive ticks, then -> IDLE (break/stuck-low line yields exactly one frame_err).
REQ-020 valid and frame_err SHALL never be high in the same cycle and SHALL each be high for exactly one clock per frame.
REQ-021 Latency: valid SHALL rise within DIV+2 clocks after the mid-stop-bit sample; the back-to-back next start edge SHALL be detected with no lost frame.
REQ-022 Counters: sample counter 4 bits wrapping 15->0; bit index $clog2(DATA_WIDTH)+1 bits; divisor $clog2(DIV+1) bits.
REQ-023 No flow control: consumer SHALL capture data_out on valid; data_out holds until the next valid.

Reset
REQ-024 On rst high, SHALL immediately force state IDLE, data_out 0, valid 0, frame_err 0, busy 0, synchronizer flops 1, all counters 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial byte; after release, a frame is received only from a new falling edge.

Structure
REQ-026 SHALL place state encoding and the DIV computation function in shared package uart_pkg (reused by the TX side).
REQ-027 SHALL instantiate one sub-module uart_baud_gen (inputs clk, rst, clear; output tick).

Verification
REQ-028 Defaults, send 0x55 with 8N1 at 432 clocks/bit -> one valid pulse, data_out=0x55, frame_err never high.
REQ-029 Send 0xA3 then 0x0F back-to-back (no idle gap) -> two valid pulses, data_out 0xA3 then 0x0F.
REQ-030 rx low pulse of 100 clocks then high -> no valid, no frame_err, busy returns 0 within 216+DIV clocks.
REQ-031 Send 0xC8 with stop bit forced low, then hold rx low 5000 clocks, then high -> exactly one frame_err, no valid, busy drops 16 ticks after rx returns high.
REQ-032 Assert rst during bit 4 of 0x3C, release, then send 0x81 -> no output for 0x3C, single valid with data_out=0x81.
REQ-033 Single 3-clock low glitch at sample 8 of a data bit of 0xFF -> majority vote masks it, data_out=0xFF.
